// File: rtl/fetch_decode_stage_pkg.sv
// Shared constants for the IF stage / IF-ID register: opcodes, PCSrc encodings,
// the canonical nop word and the operand-source helper used by hazard detection.
package fetch_decode_stage_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   localparam logic [31:0] NOP = 32'h0000_0000;

   // PCSrc from the ID control decoder; 2'b11 is unused and behaves as sequential
   typedef enum logic [1:0] {
      PCSRC_SEQ  = 2'b00,
      PCSRC_JUMP = 2'b01,
      PCSRC_JR   = 2'b10,
      PCSRC_RSVD = 2'b11
   } pcsrc_e;

   // Opcodes that read rt as a source operand (so a load into rt is a hazard)
   function automatic logic reads_rt(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/fetch_decode_stage_hazard_detect_unit.sv
// Combinational load-use detector: a load in EX whose destination is a source
// of the instruction held in IF/ID forces a one-cycle stall, unless a taken
// branch is squashing that instruction anyway.
module hazard_detect_unit
   import fetch_decode_stage_pkg::*;
(
   input  logic       id_valid,
   input  logic [5:0] id_op,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rt,
   input  logic       ex_branch_taken,
   output logic       stall
);

   logic rs_hit;
   logic rt_hit;

   // Source-register compare; $0 never carries a dependency
   always_comb begin
      rs_hit = (ex_rt == id_rs);
      rt_hit = (ex_rt == id_rt) && reads_rt(id_op);
      stall  = id_valid && ex_mem_read && (ex_rt != 5'd0) && !ex_branch_taken
               && (rs_hit || rt_hit);
   end

endmodule

// File: rtl/fetch_decode_stage.sv
// IF stage plus IF/ID pipeline register: owns the PC, captures fetched words,
// redirects on ID jumps and EX branches, stalls on load-use hazards and keeps
// saturating stall / redirect counters.
module fetch_decode_stage
   import fetch_decode_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   output logic [31:0]      imem_addr,
   input  logic [31:0]      imem_rdata,
   input  logic [1:0]       id_pcsrc,
   input  logic [31:0]      id_rs_data,
   input  logic             ex_branch_taken,
   input  logic [31:0]      ex_branch_target,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rt,
   output logic [31:0]      id_instr,
   output logic [31:0]      id_pc_plus4,
   output logic             id_valid,
   output logic             stall,
   output logic             flush_idex,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [31:0]      pc_q, pc_d;
   logic [31:0]      id_instr_q, id_instr_d;
   logic [31:0]      id_pc_plus4_q, id_pc_plus4_d;
   logic             id_valid_q, id_valid_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic             stall_w;
   logic [31:0]      pc_plus4;
   logic [31:0]      jump_target;
   pcsrc_e           pcsrc;

   hazard_detect_unit u_hazard (
      .id_valid        (id_valid_q),
      .id_op           (id_instr_q[31:26]),
      .id_rs           (id_instr_q[25:21]),
      .id_rt           (id_instr_q[20:16]),
      .ex_mem_read     (ex_mem_read),
      .ex_rt           (ex_rt),
      .ex_branch_taken (ex_branch_taken),
      .stall           (stall_w)
   );

   // Next-PC / IF-ID / counter selection: branch > stall > j > jr > sequential
   always_comb begin
      pc_d          = pc_q;
      id_instr_d    = id_instr_q;
      id_pc_plus4_d = id_pc_plus4_q;
      id_valid_d    = id_valid_q;
      stall_cnt_d   = stall_cnt_q;
      flush_cnt_d   = flush_cnt_q;

      pc_plus4    = pc_q + 32'd4;
      jump_target = {id_pc_plus4_q[31:28], id_instr_q[25:0], 2'b00};
      pcsrc       = pcsrc_e'(id_pcsrc);

      if (ex_branch_taken) begin
         pc_d       = ex_branch_target;
         id_instr_d = NOP;
         id_valid_d = 1'b0;
         if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_ONE;
      end else if (stall_w) begin
         if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_ONE;
      end else if (id_valid_q && (pcsrc == PCSRC_JUMP)) begin
         pc_d       = jump_target;
         id_instr_d = NOP;
         id_valid_d = 1'b0;
         if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_ONE;
      end else if (id_valid_q && (pcsrc == PCSRC_JR)) begin
         pc_d       = id_rs_data;
         id_instr_d = NOP;
         id_valid_d = 1'b0;
         if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_ONE;
      end else begin
         pc_d          = pc_plus4;
         id_instr_d    = imem_rdata;
         id_pc_plus4_d = pc_plus4;
         id_valid_d    = 1'b1;
      end
   end

   // State registers with synchronous active-low reset overriding all events
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q          <= RESET_PC;
         id_instr_q    <= NOP;
         id_pc_plus4_q <= 32'h0;
         id_valid_q    <= 1'b0;
         stall_cnt_q   <= '0;
         flush_cnt_q   <= '0;
      end else begin
         pc_q          <= pc_d;
         id_instr_q    <= id_instr_d;
         id_pc_plus4_q <= id_pc_plus4_d;
         id_valid_q    <= id_valid_d;
         stall_cnt_q   <= stall_cnt_d;
         flush_cnt_q   <= flush_cnt_d;
      end
   end

   // Output drive
   always_comb begin
      imem_addr   = pc_q;
      id_instr    = id_instr_q;
      id_pc_plus4 = id_pc_plus4_q;
      id_valid    = id_valid_q;
      stall       = stall_w;
      flush_idex  = ex_branch_taken;
      stall_cnt   = stall_cnt_q;
      flush_cnt   = flush_cnt_q;
   end

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Bench for fetch_decode_stage: a full-width instance plus a 3-bit-counter
// instance driven identically, compared every cycle against a rule-level model.
module tb_fetch_decode_stage;
   import fetch_decode_stage_pkg::*;

   localparam int SW = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [1:0]  id_pcsrc;
   logic [31:0] id_rs_data;
   logic        ex_branch_taken;
   logic [31:0] ex_branch_target;
   logic        ex_mem_read;
   logic [4:0]  ex_rt;

   logic [31:0] imem_addr, imem_rdata, id_instr, id_pc_plus4;
   logic        id_valid, stall, flush_idex;
   logic [15:0] stall_cnt, flush_cnt;

   logic [31:0] imem_addr_s, imem_rdata_s, id_instr_s, id_pc_plus4_s;
   logic        id_valid_s, stall_s, flush_idex_s;
   logic [SW-1:0] stall_cnt_s, flush_cnt_s;

   logic [31:0] rom [256];
   assign imem_rdata   = rom[imem_addr[9:2]];
   assign imem_rdata_s = rom[imem_addr_s[9:2]];

   fetch_decode_stage #(.RESET_PC(32'h0), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .id_pcsrc(id_pcsrc), .id_rs_data(id_rs_data), .ex_branch_taken(ex_branch_taken),
      .ex_branch_target(ex_branch_target), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
      .id_instr(id_instr), .id_pc_plus4(id_pc_plus4), .id_valid(id_valid),
      .stall(stall), .flush_idex(flush_idex), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   fetch_decode_stage #(.RESET_PC(32'h0), .CNT_W(SW)) dut_s (
      .clk(clk), .reset(reset), .imem_addr(imem_addr_s), .imem_rdata(imem_rdata_s),
      .id_pcsrc(id_pcsrc), .id_rs_data(id_rs_data), .ex_branch_taken(ex_branch_taken),
      .ex_branch_target(ex_branch_target), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
      .id_instr(id_instr_s), .id_pc_plus4(id_pc_plus4_s), .id_valid(id_valid_s),
      .stall(stall_s), .flush_idex(flush_idex_s), .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
   );

   // ---------------- scoreboard counters ----------------
   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] m_pc, m_instr, m_pc4;
   logic        m_valid;
   int          m_scnt, m_fcnt;

   function automatic int sat(input int v, input int max);
      return (v > max) ? max : v;
   endfunction

   function automatic logic model_stall();
      logic [5:0] op;
      logic [4:0] rs, rt;
      op = m_instr[31:26];
      rs = m_instr[25:21];
      rt = m_instr[20:16];
      if (!m_valid || ex_branch_taken || !ex_mem_read || ex_rt == 5'd0) return 1'b0;
      if (ex_rt == rs) return 1'b1;
      return (ex_rt == rt) && (op == 6'h00 || op == 6'h04 || op == 6'h2b);
   endfunction

   task automatic model_step();
      logic st;
      st = model_stall();
      if (!reset) begin
         m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
         m_scnt = 0; m_fcnt = 0;
      end else if (ex_branch_taken) begin
         m_pc = ex_branch_target; m_instr = 32'h0; m_valid = 1'b0; m_fcnt++;
      end else if (st) begin
         m_scnt++;
      end else if (m_valid && id_pcsrc == 2'b01) begin
         m_pc = {m_pc4[31:28], m_instr[25:0], 2'b00};
         m_instr = 32'h0; m_valid = 1'b0; m_fcnt++;
      end else if (m_valid && id_pcsrc == 2'b10) begin
         m_pc = id_rs_data; m_instr = 32'h0; m_valid = 1'b0; m_fcnt++;
      end else begin
         m_instr = rom[m_pc[9:2]];
         m_pc4   = m_pc + 32'd4;
         m_pc    = m_pc + 32'd4;
         m_valid = 1'b1;
      end
   endtask

   task automatic check_model();
      chk("imem_addr", imem_addr, m_pc);
      chk("id_instr", id_instr, m_instr);
      chk("id_pc_plus4", id_pc_plus4, m_pc4);
      chk("id_valid", id_valid, m_valid);
      chk("stall", stall, model_stall());
      chk("flush_idex", flush_idex, ex_branch_taken);
      chk("stall_cnt", stall_cnt, sat(m_scnt, 65535));
      chk("flush_cnt", flush_cnt, sat(m_fcnt, 65535));
      chk("small_state", {imem_addr_s, id_valid_s, stall_s, flush_idex_s},
          {m_pc, m_valid, model_stall(), ex_branch_taken});
      chk("small_if_id", {id_instr_s, id_pc_plus4_s}, {m_instr, m_pc4});
      chk("small_stall_cnt", stall_cnt_s, sat(m_scnt, 7));
      chk("small_flush_cnt", flush_cnt_s, sat(m_fcnt, 7));
   endtask

   // ---------------- driver tasks ----------------
   task automatic clear_inputs();
      id_pcsrc = 2'b00; id_rs_data = 32'h0; ex_branch_taken = 1'b0;
      ex_branch_target = 32'h0; ex_mem_read = 1'b0; ex_rt = 5'd0;
   endtask

   // Called at a falling edge with inputs settled; returns at the next falling edge
   task automatic step();
      #1;
      check_model();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b0;
      step();
      reset = 1'b1;
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      logic [31:0] instr;
      logic        mr;
      logic [4:0]  rt;
      logic        bt;
      logic        exp_stall;
      logic        exp_flush;
   } vec_t;

   localparam logic [31:0] I_ADD   = 32'h010A4820; // add  $9,$8,$10
   localparam logic [31:0] I_ADDI  = 32'h21490005; // addi $9,$10,5
   localparam logic [31:0] I_LW0   = 32'h8C020000; // lw   $2,0($0)
   localparam logic [31:0] I_SW    = 32'hAD0A0004; // sw   $10,4($8)
   localparam logic [31:0] I_BEQ   = 32'h110A0003; // beq  $8,$10,3
   localparam logic [31:0] I_LW    = 32'h8D0A0000; // lw   $10,0($8)
   localparam logic [31:0] I_J10   = 32'h08000010; // j    0x10

   vec_t vecs [12];

   function automatic logic [31:0] rand_instr();
      logic [5:0] ops [6];
      logic [31:0] w;
      ops[0] = OP_RTYPE; ops[1] = OP_BEQ; ops[2] = OP_SW;
      ops[3] = OP_LW;    ops[4] = 6'h08;  ops[5] = OP_J;
      w = $urandom;
      w[31:26] = ops[$urandom_range(0, 5)];
      w[25:21] = 5'($urandom_range(0, 3));
      w[20:16] = 5'($urandom_range(0, 3));
      return w;
   endfunction

   initial begin
      clear_inputs();
      reset = 1'b0;
      for (int i = 0; i < 256; i++) rom[i] = rand_instr();
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_scnt = 0; m_fcnt = 0;
      @(posedge clk);
      @(negedge clk);

      // Reset held two cycles, then sequential fetch 0,4,8
      step();
      step();
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_valid", id_valid, 1'b0);
      chk("rst_cnts", {stall_cnt, flush_cnt}, 32'h0);
      reset = 1'b1;
      #1 chk("seq_addr0", imem_addr, 32'h0);
      step();
      chk("seq_addr4", imem_addr, 32'h4);
      step();
      chk("seq_addr8", imem_addr, 32'h8);

      // Load-use table
      vecs[0]  = '{I_ADD,  1'b1, 5'd8,  1'b0, 1'b1, 1'b0};
      vecs[1]  = '{I_ADD,  1'b1, 5'd10, 1'b0, 1'b1, 1'b0};
      vecs[2]  = '{I_ADD,  1'b1, 5'd9,  1'b0, 1'b0, 1'b0};
      vecs[3]  = '{I_ADD,  1'b0, 5'd8,  1'b0, 1'b0, 1'b0};
      vecs[4]  = '{I_ADDI, 1'b1, 5'd10, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{I_ADDI, 1'b1, 5'd9,  1'b0, 1'b0, 1'b0};
      vecs[6]  = '{I_ADDI, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0};
      vecs[7]  = '{I_LW0,  1'b1, 5'd0,  1'b0, 1'b0, 1'b0};
      vecs[8]  = '{I_SW,   1'b1, 5'd10, 1'b0, 1'b1, 1'b0};
      vecs[9]  = '{I_BEQ,  1'b1, 5'd10, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{I_LW,   1'b1, 5'd10, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{I_ADD,  1'b1, 5'd8,  1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 12; i++) begin
         rom[0] = vecs[i].instr;
         do_reset();
         step();
         ex_mem_read = vecs[i].mr; ex_rt = vecs[i].rt;
         ex_branch_taken = vecs[i].bt; ex_branch_target = 32'h80;
         #1;
         chk($sformatf("vec%0d_stall", i), stall, vecs[i].exp_stall);
         chk($sformatf("vec%0d_flush", i), flush_idex, vecs[i].exp_flush);
         clear_inputs();
      end

      // Load-use stall holds PC and IF/ID for one cycle
      rom[0] = I_ADD;
      do_reset();
      step();
      ex_mem_read = 1'b1; ex_rt = 5'd8;
      #1 chk("lu_stall", stall, 1'b1);
      step();
      chk("lu_hold_pc", imem_addr, 32'h4);
      chk("lu_hold_ir", id_instr, I_ADD);
      chk("lu_scnt", stall_cnt, 16'd1);
      ex_mem_read = 1'b0;
      #1 chk("lu_release", stall, 1'b0);
      step();
      chk("lu_resume_pc", imem_addr, 32'h8);
      chk("lu_resume_ir", id_instr, rom[1]);

      // j 0x10 from id_pc_plus4 0x104
      rom[64] = I_J10;
      do_reset();
      for (int i = 0; i < 65; i++) step();
      chk("j_ir", id_instr, I_J10);
      chk("j_pc4", id_pc_plus4, 32'h104);
      id_pcsrc = 2'b01;
      step();
      chk("j_target", imem_addr, 32'h40);
      chk("j_bubble", id_valid, 1'b0);
      chk("j_fcnt", flush_cnt, 16'd1);
      id_pcsrc = 2'b00;
      step();
      chk("j_refetch", {id_valid, id_instr}, {1'b1, rom[16]});

      // Branch taken with a simultaneous load-use hazard
      rom[0] = I_ADD;
      do_reset();
      step();
      ex_mem_read = 1'b1; ex_rt = 5'd8;
      ex_branch_taken = 1'b1; ex_branch_target = 32'h200;
      #1;
      chk("br_no_stall", stall, 1'b0);
      chk("br_flush", flush_idex, 1'b1);
      step();
      clear_inputs();
      chk("br_pc", imem_addr, 32'h200);
      chk("br_bubble", id_valid, 1'b0);
      chk("br_scnt", stall_cnt, 16'd0);

      // jr to the top of memory then wrap to 0
      do_reset();
      step();
      id_pcsrc = 2'b10; id_rs_data = 32'hFFFF_FFFC;
      step();
      chk("jr_pc", imem_addr, 32'hFFFF_FFFC);
      clear_inputs();
      step();
      chk("wrap_pc", imem_addr, 32'h0);
      chk("wrap_pc4", id_pc_plus4, 32'h0);

      // Counter saturation on the narrow instance
      rom[0] = I_ADD;
      do_reset();
      step();
      ex_mem_read = 1'b1; ex_rt = 5'd8;
      for (int i = 0; i < 10; i++) step();
      chk("sat_scnt_wide", stall_cnt, 16'd10);
      chk("sat_scnt_small", stall_cnt_s, 3'h7);
      clear_inputs();
      ex_branch_taken = 1'b1;
      for (int i = 0; i < 9; i++) begin
         ex_branch_target = 32'(i) << 2;
         step();
      end
      chk("sat_fcnt_wide", flush_cnt, 16'd9);
      chk("sat_fcnt_small", flush_cnt_s, 3'h7);
      clear_inputs();

      // Randomized run against the model
      for (int i = 0; i < 256; i++) rom[i] = rand_instr();
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         reset            = ($urandom_range(0, 99) != 0);
         ex_mem_read      = ($urandom_range(0, 2) == 0);
         ex_rt            = 5'($urandom_range(0, 3));
         ex_branch_taken  = ($urandom_range(0, 9) == 0);
         ex_branch_target = $urandom;
         id_rs_data       = $urandom;
         id_pcsrc         = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         step();
      end
      clear_inputs();
      reset = 1'b1;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
